int_ctrl: RTL and testbench

- Programmable interrupt controller that sits directly downstream of the IO unit.
- Consumes the IO unit's hw_int (timer 0) plus further peripheral request lines, latches them as pending, and applies mask and priority.
- Drives a single registered irq to the CPU exception logic and exposes the in-service vector.
- Register file sits behind the IO bus decoder like the other peripherals: 2-bit word offset, write enable, write data, read data.

---
 rtl/int_ctrl_pkg.sv | 20 ++
 rtl/int_ctrl_if.sv | 26 ++
 rtl/int_prio_enc.sv | 24 ++
 rtl/int_ctrl.sv | 127 ++++++++++++
 tb/tb_int_ctrl.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared constants for the interrupt controller: bus width, register offsets
// and the request FSM state encoding.
package int_ctrl_pkg;

    localparam int ARCH_WIDTH = 32;

    localparam logic [ARCH_WIDTH-1:0] INTC_BASE_ADDR = 32'h0000_F040;

    localparam logic [1:0] INTC_PEND = 2'd0;
    localparam logic [1:0] INTC_MASK = 2'd1;
    localparam logic [1:0] INTC_MODE = 2'd2;
    localparam logic [1:0] INTC_VEC  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } intc_state_e;

endpackage

// File: rtl/int_ctrl_if.sv
// Register bus, request lines and CPU handshake between the IO side and the
// interrupt controller.
interface int_ctrl_if #(
    parameter int N_SRC = 8
);
    import int_ctrl_pkg::*;

    logic [N_SRC-1:0]      src;
    logic [1:0]            addr;
    logic                  we;
    logic [ARCH_WIDTH-1:0] wd;
    logic [ARCH_WIDTH-1:0] rd;
    logic                  irq;
    logic                  int_ack;

    modport master (
        output src, addr, we, wd, int_ack,
        input  rd, irq
    );

    modport slave (
        input  src, addr, we, wd, int_ack,
        output rd, irq
    );

endinterface

// File: rtl/int_prio_enc.sv
// Lowest-index-wins priority encoder; valid is low when no request is set,
// in which case vec reads 0.
module int_prio_enc #(
    parameter int N_SRC = 8,
    parameter int VEC_W = 5
) (
    input  logic [N_SRC-1:0] req,
    output logic [VEC_W-1:0] vec,
    output logic             valid
);

    always_comb begin
        vec   = '0;
        valid = 1'b0;
        // Scan downward so the lowest set index is the last one written.
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                vec   = VEC_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Programmable interrupt controller: pending/mask/mode registers, a single
// registered irq to the CPU and an in-service vector cleared by EOI.
//
// state      | meaning
// ST_IDLE    | irq low, waiting for an enabled pending source
// ST_REQ     | irq high, waiting for int_ack (drops back if nothing enabled)
// ST_SERVICE | irq low, vector latched, waiting for EOI write
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int N_SRC = 8,
    parameter int VEC_W = 5
) (
    input  logic         clk,
    input  logic         rst,
    int_ctrl_if.slave    bus
);

    logic [N_SRC-1:0] pend, mask, mode, src_q;
    logic [N_SRC-1:0] enabled, pend_next, w1c, ack_clr, edge_set, edge_next;
    logic [N_SRC-1:0] wd_lo;
    logic [VEC_W-1:0] winner, vec;
    logic             any, in_svc, irq_r;
    logic             wr_pend, wr_mask, wr_mode, eoi, take;
    intc_state_e      state;

    assign wd_lo   = bus.wd[N_SRC-1:0];
    assign wr_pend = bus.we && (bus.addr == INTC_PEND);
    assign wr_mask = bus.we && (bus.addr == INTC_MASK);
    assign wr_mode = bus.we && (bus.addr == INTC_MODE);
    assign eoi     = bus.we && (bus.addr == INTC_VEC);
    assign take    = (state == ST_REQ) && bus.int_ack;
    assign enabled = pend & mask;

    int_prio_enc #(
        .N_SRC (N_SRC),
        .VEC_W (VEC_W)
    ) u_prio (
        .req   (enabled),
        .vec   (winner),
        .valid (any)
    );

    always_comb begin
        w1c       = wr_pend ? wd_lo : '0;
        ack_clr   = (take && any) ? (N_SRC'(1) << winner) : '0;
        edge_set  = bus.src & ~src_q;
        // A fresh edge beats any clear landing in the same cycle.
        edge_next = (pend & ~(w1c | ack_clr)) | edge_set;
        if (wr_mode) begin
            pend_next = bus.src & ~wd_lo;
        end else begin
            pend_next = (edge_next & mode) | (bus.src & ~mode);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend  <= '0;
            mask  <= '0;
            mode  <= '0;
            src_q <= '0;
        end else begin
            pend  <= pend_next;
            src_q <= bus.src;
            if (wr_mask) mask <= wd_lo;
            if (wr_mode) mode <= wd_lo;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            irq_r  <= 1'b0;
            vec    <= '0;
            in_svc <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any) begin
                        state <= ST_REQ;
                        irq_r <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (bus.int_ack) begin
                        // With nothing enabled the encoder yields 0: a spurious ack.
                        vec    <= winner;
                        in_svc <= 1'b1;
                        state  <= ST_SERVICE;
                        irq_r  <= 1'b0;
                    end else if (!any) begin
                        state <= ST_IDLE;
                        irq_r <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (eoi) begin
                        in_svc <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    irq_r <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        bus.rd = '0;
        case (bus.addr)
            INTC_PEND: bus.rd[N_SRC-1:0] = pend;
            INTC_MASK: bus.rd[N_SRC-1:0] = mask;
            INTC_MODE: bus.rd[N_SRC-1:0] = mode;
            INTC_VEC: begin
                bus.rd[ARCH_WIDTH-1] = in_svc;
                bus.rd[VEC_W-1:0]    = vec;
            end
            default: bus.rd = '0;
        endcase
    end

    assign bus.irq = irq_r;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed and random stimulus for int_ctrl checked against a per-source
// behavioural model of pending, mask, mode and the CPU request handshake.
module tb_int_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    int_ctrl_if #(.N_SRC(8)) bus ();

    int_ctrl #(
        .N_SRC (8),
        .VEC_W (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: m_req means the CPU is being asked, m_busy means a vector is in service.
    logic [7:0] m_pend, m_mask, m_mode, m_srcq;
    logic [4:0] m_vec;
    logic       m_req, m_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [1:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            2'd0: r[7:0] = m_pend;
            2'd1: r[7:0] = m_mask;
            2'd2: r[7:0] = m_mode;
            default: begin
                r[31]  = m_busy;
                r[4:0] = m_vec;
            end
        endcase
        return r;
    endfunction

    task automatic tick(input string tag);
        logic [7:0] s, d, n_pend, n_mask, n_mode;
        logic [4:0] n_vec;
        logic       n_req, n_busy, w, ack, any, set, clr;
        logic [1:0] a;
        int         win;
        s = bus.src; d = bus.wd[7:0]; w = bus.we; a = bus.addr; ack = bus.int_ack;
        any = 1'b0;
        win = 0;
        for (int i = 7; i >= 0; i--) begin
            if (m_pend[i] && m_mask[i]) begin
                any = 1'b1;
                win = i;
            end
        end
        n_req = m_req; n_busy = m_busy; n_vec = m_vec;
        if (m_req) begin
            if (ack) begin
                n_vec  = any ? 5'(win) : 5'd0;
                n_busy = 1'b1;
                n_req  = 1'b0;
            end else if (!any) begin
                n_req = 1'b0;
            end
        end else if (m_busy) begin
            if (w && a == 2'd3) n_busy = 1'b0;
        end else if (any) begin
            n_req = 1'b1;
        end
        for (int i = 0; i < 8; i++) begin
            if (w && a == 2'd2) begin
                n_pend[i] = d[i] ? 1'b0 : s[i];
            end else if (m_mode[i]) begin
                set = s[i] && !m_srcq[i];
                clr = (w && a == 2'd0 && d[i]) || (m_req && ack && any && win == i);
                n_pend[i] = set || (m_pend[i] && !clr);
            end else begin
                n_pend[i] = s[i];
            end
        end
        n_mask = (w && a == 2'd1) ? d : m_mask;
        n_mode = (w && a == 2'd2) ? d : m_mode;
        @(posedge clk);
        #1;
        if (rst) begin
            m_pend = '0; m_mask = '0; m_mode = '0; m_srcq = '0;
            m_vec = '0; m_req = 1'b0; m_busy = 1'b0;
        end else begin
            m_pend = n_pend; m_mask = n_mask; m_mode = n_mode; m_srcq = s;
            m_vec = n_vec; m_req = n_req; m_busy = n_busy;
        end
        chk({tag, "_irq"}, {31'b0, bus.irq}, {31'b0, m_req});
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input string tag);
        bus.we   = 1'b1;
        bus.addr = a;
        bus.wd   = d;
        tick(tag);
        bus.we   = 1'b0;
        bus.wd   = '0;
    endtask

    task automatic ack(input string tag);
        bus.int_ack = 1'b1;
        tick(tag);
        bus.int_ack = 1'b0;
    endtask

    task automatic rdm(input logic [1:0] a, input string tag);
        bus.we   = 1'b0;
        bus.addr = a;
        #1;
        chk(tag, bus.rd, model_rd(a));
    endtask

    task automatic rdk(input logic [1:0] a, input logic [31:0] exp, input string tag);
        rdm(a, tag);
        chk({tag, "_const"}, bus.rd, exp);
    endtask

    task automatic ck_irq(input logic exp, input string tag);
        chk(tag, {31'b0, bus.irq}, {31'b0, exp});
    endtask

    initial begin
        checks = 0; failures = 0;
        m_pend = '0; m_mask = '0; m_mode = '0; m_srcq = '0;
        m_vec = '0; m_req = 1'b0; m_busy = 1'b0;
        bus.src = '0; bus.addr = '0; bus.we = 1'b0; bus.wd = '0; bus.int_ack = 1'b0;

        rst = 1'b1;
        tick("reset");
        rst = 1'b0;
        rdk(2'd0, 32'h0, "rst_pend");
        rdk(2'd1, 32'h0, "rst_mask");
        rdk(2'd2, 32'h0, "rst_mode");
        rdk(2'd3, 32'h0, "rst_vec");
        ck_irq(1'b0, "rst_irq");

        // Edge source 0: pend one cycle after the edge, irq one cycle later.
        wr(2'd1, 32'h1, "e0_mask");
        wr(2'd2, 32'h1, "e0_mode");
        bus.src = 8'h01;
        tick("e0_edge");
        bus.src = 8'h00;
        rdk(2'd0, 32'h1, "e0_pend");
        ck_irq(1'b0, "e0_irq_early");
        tick("e0_req");
        ck_irq(1'b1, "e0_irq");
        ack("e0_ack");
        rdk(2'd3, 32'h8000_0000, "e0_vec");
        rdk(2'd0, 32'h0, "e0_pend_clr");
        ck_irq(1'b0, "e0_irq_svc");
        wr(2'd3, 32'h0, "e0_eoi");
        tick("e0_idle");
        ck_irq(1'b0, "e0_irq_after_eoi");

        // Level sources 2 and 3.
        wr(2'd2, 32'h0, "lv_mode");
        wr(2'd1, 32'h0C, "lv_mask");
        bus.src = 8'h0C;
        tick("lv_src");
        tick("lv_req");
        ck_irq(1'b1, "lv_irq");
        ack("lv_ack");
        rdk(2'd3, 32'h8000_0002, "lv_vec2");
        tick("lv_svc1");
        tick("lv_svc2");
        ck_irq(1'b0, "lv_irq_svc");
        wr(2'd3, 32'h0, "lv_eoi");
        ck_irq(1'b0, "lv_irq_eoi_edge");
        tick("lv_rereq");
        ck_irq(1'b1, "lv_irq_reassert");
        bus.src = 8'h08;
        tick("lv_drop2");
        ack("lv_ack3");
        rdk(2'd3, 32'h8000_0003, "lv_vec3");
        bus.src = 8'h00;
        wr(2'd3, 32'h0, "lv_eoi2");
        tick("lv_t1");
        tick("lv_t2");

        // Mask removed while the CPU is being asked.
        wr(2'd1, 32'h0, "mk_mask0");
        wr(2'd2, 32'h2, "mk_mode");
        wr(2'd1, 32'h2, "mk_mask");
        bus.src = 8'h02;
        tick("mk_edge");
        bus.src = 8'h00;
        tick("mk_req");
        ck_irq(1'b1, "mk_irq");
        wr(2'd1, 32'h0, "mk_unmask");
        tick("mk_drop");
        ck_irq(1'b0, "mk_irq_drop");
        rdk(2'd0, 32'h2, "mk_pend_kept");
        wr(2'd1, 32'h2, "mk_remask");
        tick("mk_rereq");
        ck_irq(1'b1, "mk_irq_reassert");
        ack("mk_ack");
        rdk(2'd3, 32'h8000_0001, "mk_vec");
        wr(2'd3, 32'h0, "mk_eoi");

        // Edge set collides with W1C of the same bit; then EOI while idle.
        wr(2'd1, 32'h0, "sw_mask0");
        bus.src  = 8'h02;
        bus.we   = 1'b1;
        bus.addr = 2'd0;
        bus.wd   = 32'h2;
        tick("sw_collide");
        bus.we   = 1'b0;
        bus.wd   = '0;
        rdk(2'd0, 32'h2, "sw_pend_set_wins");
        wr(2'd3, 32'h0, "sw_eoi_idle");
        ck_irq(1'b0, "sw_irq_idle");
        rdm(2'd3, "sw_vec_idle");
        tick("sw_idle2");
        ck_irq(1'b0, "sw_irq_idle2");

        // Reset while in service with work pending.
        wr(2'd1, 32'h2, "rs_mask");
        tick("rs_req");
        ck_irq(1'b1, "rs_irq");
        ack("rs_ack");
        bus.src = 8'h00;
        tick("rs_low");
        bus.src = 8'h02;
        tick("rs_edge");
        rdk(2'd0, 32'h2, "rs_pend");
        rst = 1'b1;
        tick("rs_reset");
        rst = 1'b0;
        ck_irq(1'b0, "rs_irq0");
        rdk(2'd0, 32'h0, "rs_pend0");
        rdk(2'd1, 32'h0, "rs_mask0");
        rdk(2'd2, 32'h0, "rs_mode0");
        rdk(2'd3, 32'h0, "rs_vec0");
        bus.src = 8'h00;
        tick("rs_settle");

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            bus.src     = 8'($urandom);
            bus.we      = ($urandom_range(0, 2) == 0);
            bus.addr    = 2'($urandom_range(0, 3));
            bus.wd      = $urandom;
            bus.int_ack = ($urandom_range(0, 3) == 0);
            tick("rnd");
            bus.we      = 1'b0;
            bus.int_ack = 1'b0;
            rdm(2'($urandom_range(0, 3)), "rnd_rd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
